// File: rtl/regfile_pkg.sv
// Shared constants for the MSP430-style register bank: register indices,
// addressing-mode encodings, status-register bit positions and the R4..R15 reset table.
package regfile_pkg;

    localparam int NUM_REGS = 16;

    localparam logic [3:0] IDX_PC  = 4'd0;
    localparam logic [3:0] IDX_SP  = 4'd1;
    localparam logic [3:0] IDX_SR  = 4'd2;
    localparam logic [3:0] IDX_CG2 = 4'd3;

    typedef enum logic [1:0] {
        AS_REG = 2'b00,
        AS_IDX = 2'b01,
        AS_IND = 2'b10,
        AS_INC = 2'b11
    } as_mode_e;

    typedef enum logic {
        AD_REG = 1'b0,
        AD_IDX = 1'b1
    } ad_mode_e;

    localparam int SR_C = 0;
    localparam int SR_Z = 1;
    localparam int SR_N = 2;
    localparam int SR_V = 8;

    // Power-up contents of the general-purpose registers; R0..R3 return 0 here.
    function automatic logic [15:0] gpr_reset_value(input logic [3:0] idx);
        case (idx)
            4'd4:    return 16'hFFFF;
            4'd5:    return 16'hFFFF;
            4'd6:    return 16'hFFFF;
            4'd7:    return 16'hA55A;
            4'd8:    return 16'hFFFF;
            4'd9:    return 16'h0116;
            4'd10:   return 16'h1AF8;
            4'd11:   return 16'hFFFF;
            4'd12:   return 16'h0004;
            4'd13:   return 16'h0000;
            4'd14:   return 16'h1A1A;
            4'd15:   return 16'h4400;
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/regfile_cg.sv
// Source-operand constant generator: R2/R3 combined with the source addressing
// mode yield fixed constants; every other register passes through.
module regfile_cg
    import regfile_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [3:0]    i_src_a,
    input  logic [1:0]    i_as_mode,
    input  logic [DW-1:0] i_reg_value,
    output logic [DW-1:0] o_src_data
);

    always_comb begin
        o_src_data = i_reg_value;
        if (i_src_a == IDX_SR) begin
            case (as_mode_e'(i_as_mode))
                AS_REG: o_src_data = i_reg_value;
                AS_IDX: o_src_data = '0;
                AS_IND: o_src_data = DW'(4);
                AS_INC: o_src_data = DW'(8);
            endcase
        end else if (i_src_a == IDX_CG2) begin
            case (as_mode_e'(i_as_mode))
                AS_REG: o_src_data = '0;
                AS_IDX: o_src_data = DW'(1);
                AS_IND: o_src_data = DW'(2);
                AS_INC: o_src_data = '1;
            endcase
        end
    end

endmodule

// File: rtl/register_bank.sv
// Sixteen-entry MSP430/MSP430X register file with PC/SP/SR special handling,
// autoincrement, branch and flag update; reads are combinational from current state.
module register_bank
    import regfile_pkg::*;
#(
    parameter int            DW     = 16,
    parameter logic [DW-1:0] PC_RST = '0,
    parameter logic [DW-1:0] SP_RST = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    src_a,
    input  logic [1:0]    as_mode,
    output logic [DW-1:0] src_data,
    input  logic [3:0]    dst_a,
    input  logic          ad_mode,
    output logic [DW-1:0] dst_data,
    input  logic          wr_en,
    input  logic [3:0]    wr_a,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_bw,
    input  logic          inc_en,
    input  logic [3:0]    inc_a,
    input  logic          inc_bw,
    input  logic          pc_inc,
    input  logic          branch,
    input  logic [DW-1:0] branch_addr,
    input  logic          sr_we,
    input  logic [3:0]    flags_in,
    output logic [DW-1:0] pc,
    output logic [DW-1:0] sp,
    output logic [DW-1:0] sr,
    output logic [3:0]    flags_out
);

    logic [DW-1:0] r_regs [NUM_REGS];
    logic [DW-1:0] w_next [NUM_REGS];
    logic [DW-1:0] w_wr_value;
    logic [DW-1:0] w_gpr_step;

    function automatic logic [DW-1:0] reg_reset(input int idx);
        case (idx)
            0:       return PC_RST;
            1:       return SP_RST;
            default: return DW'(gpr_reset_value(4'(idx)));
        endcase
    endfunction

    assign w_wr_value = wr_bw ? {{(DW-8){1'b0}}, wr_data[7:0]} : wr_data;
    assign w_gpr_step = inc_bw ? DW'(1) : DW'(2);

    // Later assignments override earlier ones, so statement order encodes priority.
    always_comb begin
        // NOTE: start from current state so every path assigns every entry; no latches.
        w_next = r_regs;
        if (inc_en && inc_a >= 4'd4)
            w_next[inc_a] = r_regs[inc_a] + w_gpr_step;
        if (inc_en && inc_a == IDX_SP)
            w_next[IDX_SP] = r_regs[IDX_SP] + DW'(2);
        if (sr_we) begin
            w_next[IDX_SR][SR_V] = flags_in[3];
            w_next[IDX_SR][SR_N] = flags_in[2];
            w_next[IDX_SR][SR_Z] = flags_in[1];
            w_next[IDX_SR][SR_C] = flags_in[0];
        end
        if (pc_inc || (inc_en && inc_a == IDX_PC))
            w_next[IDX_PC] = r_regs[IDX_PC] + DW'(2);
        if (branch)
            w_next[IDX_PC] = {branch_addr[DW-1:1], 1'b0};
        if (wr_en && wr_a != IDX_CG2) begin
            w_next[wr_a] = w_wr_value;
            if (wr_a == IDX_PC || wr_a == IDX_SP)
                w_next[wr_a][0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: every entry has a defined reset value, so the whole file is reset, not just PC/SP/SR.
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= reg_reset(i);
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge state.
            r_regs <= w_next;
        end
    end

    regfile_cg #(.DW(DW)) u_cg (
        .i_src_a    (src_a),
        .i_as_mode  (as_mode),
        .i_reg_value(r_regs[src_a]),
        .o_src_data (src_data)
    );

    always_comb begin
        dst_data = r_regs[dst_a];
        if (dst_a == IDX_CG2 || (dst_a == IDX_SR && ad_mode == AD_IDX))
            dst_data = '0;
    end

    assign pc        = r_regs[IDX_PC];
    assign sp        = r_regs[IDX_SP];
    assign sr        = r_regs[IDX_SR];
    assign flags_out = {r_regs[IDX_SR][SR_V], r_regs[IDX_SR][SR_N],
                        r_regs[IDX_SR][SR_Z], r_regs[IDX_SR][SR_C]};

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: stimulus pushes model-derived expectations,
// a negedge monitor drains and compares them against the live outputs.
module tb_register_bank;

    localparam int            DW     = 16;
    localparam logic [DW-1:0] PC_RST = 16'h0C00;
    localparam logic [DW-1:0] SP_RST = 16'h0400;
    localparam logic [DW-1:0] ONES   = '1;

    logic          clk;
    logic          reset;
    logic [3:0]    src_a;
    logic [1:0]    as_mode;
    logic [DW-1:0] src_data;
    logic [3:0]    dst_a;
    logic          ad_mode;
    logic [DW-1:0] dst_data;
    logic          wr_en;
    logic [3:0]    wr_a;
    logic [DW-1:0] wr_data;
    logic          wr_bw;
    logic          inc_en;
    logic [3:0]    inc_a;
    logic          inc_bw;
    logic          pc_inc;
    logic          branch;
    logic [DW-1:0] branch_addr;
    logic          sr_we;
    logic [3:0]    flags_in;
    logic [DW-1:0] pc;
    logic [DW-1:0] sp;
    logic [DW-1:0] sr;
    logic [3:0]    flags_out;

    register_bank #(.DW(DW), .PC_RST(PC_RST), .SP_RST(SP_RST)) dut (
        .clk        (clk),
        .reset      (reset),
        .src_a      (src_a),
        .as_mode    (as_mode),
        .src_data   (src_data),
        .dst_a      (dst_a),
        .ad_mode    (ad_mode),
        .dst_data   (dst_data),
        .wr_en      (wr_en),
        .wr_a       (wr_a),
        .wr_data    (wr_data),
        .wr_bw      (wr_bw),
        .inc_en     (inc_en),
        .inc_a      (inc_a),
        .inc_bw     (inc_bw),
        .pc_inc     (pc_inc),
        .branch     (branch),
        .branch_addr(branch_addr),
        .sr_we      (sr_we),
        .flags_in   (flags_in),
        .pc         (pc),
        .sp         (sp),
        .sr         (sr),
        .flags_out  (flags_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {SEL_SRC, SEL_DST, SEL_PC, SEL_SP, SEL_SR, SEL_FLAGS} sel_e;
    typedef struct {
        string         name;
        sel_e          sel;
        logic [DW-1:0] exp;
    } rec_t;

    rec_t          sb_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] m_regs [16];

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] tb_reset_value(input int i);
        case (i)
            0:  return PC_RST;
            1:  return SP_RST;
            4:  return 16'hFFFF;
            5:  return 16'hFFFF;
            6:  return 16'hFFFF;
            7:  return 16'hA55A;
            8:  return 16'hFFFF;
            9:  return 16'h0116;
            10: return 16'h1AF8;
            11: return 16'hFFFF;
            12: return 16'h0004;
            13: return 16'h0000;
            14: return 16'h1A1A;
            15: return 16'h4400;
            default: return '0;
        endcase
    endfunction

    function automatic logic [DW-1:0] add_mod(input logic [DW-1:0] v, input int step);
        return DW'((int'(v) + step) % (1 << DW));
    endfunction

    function automatic logic [DW-1:0] m_src(input logic [3:0] a, input logic [1:0] m);
        if (a == 4'd2) begin
            case (m)
                2'd0:    return m_regs[2];
                2'd1:    return '0;
                2'd2:    return DW'(4);
                default: return DW'(8);
            endcase
        end
        if (a == 4'd3) begin
            case (m)
                2'd0:    return '0;
                2'd1:    return DW'(1);
                2'd2:    return DW'(2);
                default: return ONES;
            endcase
        end
        return m_regs[a];
    endfunction

    function automatic logic [DW-1:0] m_dst(input logic [3:0] a, input logic ad);
        if (a == 4'd3 || (a == 4'd2 && ad)) return '0;
        return m_regs[a];
    endfunction

    // Apply one clock edge's worth of the register rules to the model.
    task automatic model_edge();
        logic [DW-1:0] nxt [16];
        logic [DW-1:0] wv;
        logic          wr_hit;
        logic          inc_hit;
        if (reset) begin
            for (int i = 0; i < 16; i++) m_regs[i] = tb_reset_value(i);
            return;
        end
        nxt = m_regs;
        wv  = wr_bw ? (wr_data & DW'(16'h00FF)) : wr_data;
        for (int i = 0; i < 16; i++) begin
            wr_hit  = wr_en && (int'(wr_a) == i);
            inc_hit = inc_en && (int'(inc_a) == i);
            if (i == 0) begin
                if (wr_hit)                 nxt[i] = {wv[DW-1:1], 1'b0};
                else if (branch)            nxt[i] = {branch_addr[DW-1:1], 1'b0};
                else if (pc_inc || inc_hit) nxt[i] = add_mod(m_regs[i], 2);
            end else if (i == 1) begin
                if (wr_hit)       nxt[i] = {wv[DW-1:1], 1'b0};
                else if (inc_hit) nxt[i] = add_mod(m_regs[i], 2);
            end else if (i == 2) begin
                if (wr_hit) nxt[i] = wv;
                else if (sr_we)
                    nxt[i] = (m_regs[i] & ~DW'(16'h0107)) |
                             DW'({flags_in[3], 5'b00000, flags_in[2:0]});
            end else if (i == 3) begin
                nxt[i] = '0;
            end else begin
                if (wr_hit)       nxt[i] = wv;
                else if (inc_hit) nxt[i] = add_mod(m_regs[i], inc_bw ? 1 : 2);
            end
        end
        m_regs = nxt;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        rec_t          r;
        logic [DW-1:0] act;
        while (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            case (r.sel)
                SEL_SRC:   act = src_data;
                SEL_DST:   act = dst_data;
                SEL_PC:    act = pc;
                SEL_SP:    act = sp;
                SEL_SR:    act = sr;
                default:   act = DW'(flags_out);
            endcase
            n_cmp++;
            if (act !== r.exp) begin
                n_err++;
                $display("FAIL %s: actual=%h expected=%h", r.name, act, r.exp);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        reset  = 1'b0;
        wr_en  = 1'b0;
        inc_en = 1'b0;
        pc_inc = 1'b0;
        branch = 1'b0;
        sr_we  = 1'b0;
        wr_bw  = 1'b0;
        inc_bw = 1'b0;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic lit(input string name, input sel_e sel, input logic [DW-1:0] exp);
        rec_t r;
        r.name = name;
        r.sel  = sel;
        r.exp  = exp;
        sb_q.push_back(r);
    endtask

    task automatic look(input string tag, input logic [3:0] sa, input logic [1:0] am,
                        input logic [3:0] da, input logic ad);
        src_a   = sa;
        as_mode = am;
        dst_a   = da;
        ad_mode = ad;
        lit($sformatf("%s src R%0d/%0d", tag, sa, am), SEL_SRC, m_src(sa, am));
        lit($sformatf("%s dst R%0d/%0d", tag, da, ad), SEL_DST, m_dst(da, ad));
        lit({tag, " pc"}, SEL_PC, m_regs[0]);
        lit({tag, " sp"}, SEL_SP, m_regs[1]);
        lit({tag, " sr"}, SEL_SR, m_regs[2]);
        lit({tag, " flags"}, SEL_FLAGS,
            DW'({m_regs[2][8], m_regs[2][2], m_regs[2][1], m_regs[2][0]}));
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [DW-1:0] d, input logic bw);
        wr_en   = 1'b1;
        wr_a    = a;
        wr_data = d;
        wr_bw   = bw;
    endtask

    task automatic inc(input logic [3:0] a, input logic bw);
        inc_en = 1'b1;
        inc_a  = a;
        inc_bw = bw;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [DW-1:0] cg_exp [8];
        cg_exp = '{16'h0105, 16'h0000, 16'h0004, 16'h0008,
                   16'h0000, 16'h0001, 16'h0002, ONES};

        idle();
        src_a = '0; as_mode = '0; dst_a = '0; ad_mode = 1'b0;
        wr_a = '0; wr_data = '0; inc_a = '0; branch_addr = '0; flags_in = '0;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;

        reset = 1'b1; step();
        reset = 1'b1; step();
        look("reset", 4'd7, 2'd0, 4'd15, 1'b0);
        lit("reset R7", SEL_SRC, 16'hA55A);
        lit("reset R15", SEL_DST, 16'h4400);
        lit("reset pc", SEL_PC, PC_RST);
        lit("reset sr", SEL_SR, 16'h0000);
        sync();

        // Constant generator over every R2/R3 mode with SR=0105.
        wr(4'd2, 16'h0105, 1'b0); step();
        for (int k = 0; k < 8; k++) begin
            look("cg", (k < 4) ? 4'd2 : 4'd3, 2'(k), 4'd2, 1'(k & 1));
            lit($sformatf("cg literal %0d", k), SEL_SRC, cg_exp[k]);
            sync();
        end
        look("dst R3", 4'd0, 2'd0, 4'd3, 1'b0); sync();

        // Autoincrement of a GPR and SP.
        wr(4'd5, 16'h1234, 1'b0); step(); sync();
        inc(4'd5, 1'b1); step();
        look("inc byte", 4'd5, 2'd0, 4'd5, 1'b0); lit("R5 +1", SEL_SRC, 16'h1235); sync();
        inc(4'd5, 1'b0); step();
        look("inc word", 4'd5, 2'd0, 4'd5, 1'b0); lit("R5 +2", SEL_SRC, 16'h1237); sync();
        wr(4'd5, 16'hFFFF, 1'b0); step(); sync();
        inc(4'd5, 1'b0); step();
        look("inc wrap", 4'd5, 2'd0, 4'd5, 1'b0); lit("R5 wrap", SEL_SRC, 16'h0001); sync();
        wr(4'd1, 16'h0000, 1'b0); step(); sync();
        inc(4'd1, 1'b1); step();
        look("sp inc", 4'd1, 2'd0, 4'd1, 1'b0); lit("SP step 2", SEL_SP, 16'h0002); sync();
        wr(4'd6, 16'h1000, 1'b0); inc(4'd6, 1'b0); step();
        look("wr beats inc", 4'd6, 2'd0, 4'd6, 1'b0); lit("R6 wr wins", SEL_SRC, 16'h1000); sync();
        inc(4'd2, 1'b0); step();
        look("inc SR ignored", 4'd2, 2'd0, 4'd2, 1'b0); lit("SR unchanged", SEL_SR, 16'h0105); sync();

        // PC priority.
        wr(4'd0, 16'h0100, 1'b0); step(); sync();
        pc_inc = 1'b1; inc(4'd0, 1'b0); step();
        look("pc once", 4'd0, 2'd0, 4'd0, 1'b0); lit("PC +2 once", SEL_PC, 16'h0102); sync();
        branch = 1'b1; branch_addr = 16'h2001; pc_inc = 1'b1; step();
        look("branch", 4'd0, 2'd0, 4'd0, 1'b0); lit("PC branch", SEL_PC, 16'h2000); sync();
        wr(4'd0, 16'h3000, 1'b0); branch = 1'b1; branch_addr = 16'h4444; step();
        look("wr beats branch", 4'd0, 2'd0, 4'd0, 1'b0); lit("PC wr wins", SEL_PC, 16'h3000); sync();
        wr(4'd0, 16'hFFFE, 1'b0); step(); sync();
        pc_inc = 1'b1; step();
        look("pc wrap", 4'd0, 2'd0, 4'd0, 1'b0); lit("PC wrap", SEL_PC, 16'h0000); sync();

        // Flag update.
        wr(4'd2, 16'h0008, 1'b0); step(); sync();
        sr_we = 1'b1; flags_in = 4'b1111; step();
        look("sr_we", 4'd2, 2'd0, 4'd2, 1'b0);
        lit("SR flags", SEL_SR, 16'h010F); lit("flags_out", SEL_FLAGS, 16'h000F); sync();
        wr(4'd2, 16'h0000, 1'b0); sr_we = 1'b1; flags_in = 4'b1111; step();
        look("wr beats sr_we", 4'd2, 2'd0, 4'd2, 1'b0); lit("SR wr wins", SEL_SR, 16'h0000); sync();

        // R3 writes, byte writes, reset beats write.
        wr(4'd3, 16'h5555, 1'b0); step();
        look("R3 write", 4'd3, 2'd0, 4'd3, 1'b0); lit("R3 reads 0", SEL_SRC, 16'h0000); sync();
        wr(4'd9, 16'hABCD, 1'b1); step();
        look("byte write", 4'd9, 2'd0, 4'd9, 1'b0); lit("R9 byte", SEL_SRC, 16'h00CD); sync();
        reset = 1'b1; wr(4'd9, 16'h1111, 1'b0); step();
        look("reset beats wr", 4'd9, 2'd0, 4'd9, 1'b0);
        lit("R9 reset", SEL_SRC, 16'h0116); lit("PC reset", SEL_PC, PC_RST); sync();

        // Randomised traffic with biased index collisions.
        for (int n = 0; n < 400; n++) begin
            reset       = ($urandom_range(0, 29) == 0);
            wr_en       = 1'($urandom_range(0, 1));
            wr_a        = 4'($urandom);
            wr_data     = DW'($urandom);
            wr_bw       = 1'($urandom_range(0, 1));
            inc_en      = 1'($urandom_range(0, 1));
            inc_a       = ($urandom_range(0, 2) == 0) ? wr_a : 4'($urandom);
            inc_bw      = 1'($urandom_range(0, 1));
            pc_inc      = ($urandom_range(0, 2) == 0);
            branch      = ($urandom_range(0, 3) == 0);
            branch_addr = DW'($urandom);
            sr_we       = 1'($urandom_range(0, 1));
            flags_in    = 4'($urandom);
            step();
            look("rand", 4'($urandom), 2'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
            sync();
        end

        sync();
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: pending=%0d required=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
